stage_instruction_decode: RTL and testbench
===========================================

// Module: stage_instruction_decode
// PURPOSE
//  Decode/operand-fetch stage: sits directly downstream of instruction fetch, consuming its latched
//  instr_bits. Drives register-file read addresses, waits the register-file read latency, then
//  latches opcode fields, the sign-extended immediate and both source operand values for execute.
//  Detects unsupported opcodes and halts the stage permanently until reset.
// PARAMETERS
//  XLEN               32  datapath / register width
//  ILEN               32  instruction width
//  REG_READ_LATENCY   1   register-file read latency in cycles; legal range 0..3
// PORTS
//  clock        in   1     clock
//  reset        in   1     reset, synchronous, active-high
//  enable       in   1     stage active; upstream holds instr_bits stable while high
//  instr_bits   in   ILEN  instruction word from fetch
//  rf_rs1_data  in   XLEN  register-file read data, port 1
//  rf_rs2_data  in   XLEN  register-file read data, port 2
//  rf_rs1_addr  out  5     instr_bits[19:15], combinational
//  rf_rs2_addr  out  5     instr_bits[24:20], combinational
//  is_complete  out  1     decode finished this cycle; outputs below update on this edge
//  is_halted    out  1     sticky illegal-opcode flag
//  opcode       out  7     latched instr_bits[6:0]
//  rd           out  5     latched instr_bits[11:7]
//  funct3       out  3     latched instr_bits[14:12]
//  funct7       out  7     latched instr_bits[31:25]
//  imm          out  XLEN  latched, sign-extended immediate
//  rs1_value    out  XLEN  latched operand 1
//  rs2_value    out  XLEN  latched operand 2
// BEHAVIOUR
//  - Reset: counter <= REG_READ_LATENCY, is_halted <= 0, all latched outputs <= 0.
//  - Counter (2 bits): enable high -> decrement each cycle, saturating at 0; enable low -> reload
//    REG_READ_LATENCY. Dropping enable mid-count aborts; no outputs change.
//  - read_complete = (counter == 0). Latency: enable first high in cycle N -> is_complete in
//    cycle N+REG_READ_LATENCY (combinational); latched outputs visible from the next cycle.
//  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011,
//    LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
//  - next_halted = is_halted | (enable & read_complete & opcode illegal).
//  - is_complete = enable & read_complete & ~is_halted & ~next_halted. Illegal opcode never
//    completes; is_halted rises next edge and holds until reset; enable ignored while halted.
//  - Immediate (inst = instr_bits), all sign-extended from inst[31]:
//    I (JALR, LOAD, OP-IMM, SYSTEM): inst[31:20]
//    S: {inst[31:25], inst[11:7]}
//    B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
//    U: {inst[31:12], 12'b0}   J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
//    R (OP): 0.
//  - Operands: rs1_value = 0 if rs1 index 0 or format U/J, else rf_rs1_data;
//    rs2_value = 0 if rs2 index 0 or format not R/S/B, else rf_rs2_data.
//  - All latched fields update only on cycles with is_complete = 1; otherwise they hold.
//  - Reset asserted mid-count or while halted wins: state returns to reset values next edge.
// TESTING
//  1 LAT=1, instr 0x00500093 (addi x1,x0,5), enable 1 cycle early -> is_complete 1 cycle later,
//    then opcode 0010011, rd 1, imm 5, rs1_value 0.
//  2 add x3,x1,x2 (0x002081B3), rf data 7/9 -> rs1_value 7, rs2_value 9, imm 0, funct7 0.
//  3 beq x0,x0,-4 (0xFE000EE3) -> imm 0xFFFFFFFC; lui 0x12345 (0x123450B7) -> imm 0x12345000.
//  4 instr 0xFFFFFFFF with enable -> is_complete never 1, is_halted 1 next cycle and sticky
//    under further enables; reset -> is_halted 0.
//  5 LAT=2, enable high 1 cycle then low, then high 2 cycles -> no completion until the counter
//    reaches 0 in the second run; outputs unchanged before that.
//  6 reset pulse during an active count -> no is_complete, all outputs 0 afterward.

Source files
------------

// File: rtl/stage_instruction_decode.sv
// Decode/operand-fetch stage: drives register-file read addresses, waits the
// read latency, then latches decoded fields, immediate and operands.
// Ports: clock, reset (sync, active-high), enable, instr_bits, rf_rs1_data,
//   rf_rs2_data -> rf_rs1_addr, rf_rs2_addr, is_complete, is_halted,
//   opcode, rd, funct3, funct7, imm, rs1_value, rs2_value.
module stage_instruction_decode #(
    parameter int XLEN             = 32,
    parameter int ILEN             = 32,
    parameter int REG_READ_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [ILEN-1:0] instr_bits,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    output logic            is_complete,
    output logic            is_halted,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value
);

    localparam logic [1:0] LAT = 2'(REG_READ_LATENCY);

    logic [31:0]     inst;
    logic [1:0]      counter;
    logic            read_complete;
    logic            next_halted;
    logic            legal;
    logic            fmt_r;
    logic            fmt_i;
    logic            fmt_s;
    logic            fmt_b;
    logic            fmt_u;
    logic            fmt_j;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign inst        = instr_bits[31:0];
    assign rf_rs1_addr = inst[19:15];
    assign rf_rs2_addr = inst[24:20];

    // Opcode classification into instruction formats
    always_comb begin
        fmt_r = 1'b0;
        fmt_i = 1'b0;
        fmt_s = 1'b0;
        fmt_b = 1'b0;
        fmt_u = 1'b0;
        fmt_j = 1'b0;
        legal = 1'b1;
        case (inst[6:0])
            7'b0110111: fmt_u = 1'b1;
            7'b0010111: fmt_u = 1'b1;
            7'b1101111: fmt_j = 1'b1;
            7'b1100111: fmt_i = 1'b1;
            7'b1100011: fmt_b = 1'b1;
            7'b0000011: fmt_i = 1'b1;
            7'b0100011: fmt_s = 1'b1;
            7'b0010011: fmt_i = 1'b1;
            7'b0110011: fmt_r = 1'b1;
            7'b1110011: fmt_i = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        if (fmt_i) imm32 = {{20{inst[31]}}, inst[31:20]};
        if (fmt_s) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        if (fmt_b) imm32 = {{20{inst[31]}}, inst[7], inst[30:25],
                            inst[11:8], 1'b0};
        if (fmt_u) imm32 = {inst[31:12], 12'd0};
        if (fmt_j) imm32 = {{12{inst[31]}}, inst[19:12], inst[20],
                            inst[30:21], 1'b0};
    end

    assign imm_ext = XLEN'($signed(imm32));

    // U/J formats carry no rs1; only R/S/B read rs2; x0 always reads zero
    assign op1 = (rf_rs1_addr == 5'd0 || fmt_u || fmt_j) ? '0 : rf_rs1_data;
    assign op2 = (rf_rs2_addr != 5'd0 && (fmt_r || fmt_s || fmt_b))
               ? rf_rs2_data : '0;

    assign read_complete = (counter == 2'd0);
    assign next_halted   = is_halted | (enable & read_complete & ~legal);
    assign is_complete   = enable & read_complete & ~is_halted & ~next_halted;

    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= LAT;
        end else if (enable) begin
            counter <= read_complete ? 2'd0 : counter - 2'd1;
        end else begin
            counter <= LAT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            is_halted <= 1'b0;
        end else begin
            is_halted <= next_halted;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opcode    <= '0;
            rd        <= '0;
            funct3    <= '0;
            funct7    <= '0;
            imm       <= '0;
            rs1_value <= '0;
            rs2_value <= '0;
        end else if (is_complete) begin
            opcode    <= inst[6:0];
            rd        <= inst[11:7];
            funct3    <= inst[14:12];
            funct7    <= inst[31:25];
            imm       <= imm_ext;
            rs1_value <= op1;
            rs2_value <= op2;
        end
    end

endmodule

// File: tb/tb_stage_instruction_decode.sv
// Directed bench for stage_instruction_decode: two instances with read
// latencies 1 and 2, sharing clock, reset, instruction and register data.
module tb_stage_instruction_decode;

    logic        clock;
    logic        reset;
    logic        en1;
    logic        en2;
    logic [31:0] instr;
    logic [31:0] rf1;
    logic [31:0] rf2;

    logic [4:0]  a1_1, a2_1, rd1, a1_2, a2_2, rd2;
    logic        c1, h1, c2, h2;
    logic [6:0]  op1, f7_1, op2, f7_2;
    logic [2:0]  f3_1, f3_2;
    logic [31:0] imm1, v1a, v1b, imm2, v2a, v2b;

    int vectors = 0;
    int miscompares = 0;

    stage_instruction_decode #(.REG_READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .enable(en1), .instr_bits(instr),
        .rf_rs1_data(rf1), .rf_rs2_data(rf2),
        .rf_rs1_addr(a1_1), .rf_rs2_addr(a2_1),
        .is_complete(c1), .is_halted(h1), .opcode(op1), .rd(rd1),
        .funct3(f3_1), .funct7(f7_1), .imm(imm1),
        .rs1_value(v1a), .rs2_value(v1b)
    );

    stage_instruction_decode #(.REG_READ_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .instr_bits(instr),
        .rf_rs1_data(rf1), .rf_rs2_data(rf2),
        .rf_rs1_addr(a1_2), .rf_rs2_addr(a2_2),
        .is_complete(c2), .is_halted(h2), .opcode(op2), .rd(rd2),
        .funct3(f3_2), .funct7(f7_2), .imm(imm2),
        .rs1_value(v2a), .rs2_value(v2b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        en1   = 1'b0;
        en2   = 1'b0;
        instr = '0;
        rf1   = '0;
        rf2   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0; #1;
        chk("rst_complete", 32'(c1), 32'd0);
        chk("rst_halted", 32'(h1), 32'd0);
        chk("rst_opcode", 32'(op1), 32'd0);
        chk("rst_imm", imm1, 32'd0);
        chk("rst_rs1", v1a, 32'd0);

        // addi x1,x0,5 with latency 1
        @(negedge clock);
        instr = 32'h00500093; rf1 = 32'h11; rf2 = 32'h22; en1 = 1'b1; #1;
        chk("t1_early", 32'(c1), 32'd0);
        chk("t1_rs2addr", 32'(a2_1), 32'd5);
        @(negedge clock); #1;
        chk("t1_complete", 32'(c1), 32'd1);
        @(negedge clock); en1 = 1'b0; #1;
        chk("t1_opcode", 32'(op1), 32'h13);
        chk("t1_rd", 32'(rd1), 32'd1);
        chk("t1_imm", imm1, 32'd5);
        chk("t1_rs1", v1a, 32'd0);
        chk("t1_rs2", v1b, 32'd0);
        chk("t1_idle", 32'(c1), 32'd0);

        // add x3,x1,x2
        @(negedge clock);
        instr = 32'h002081B3; rf1 = 32'd7; rf2 = 32'd9; en1 = 1'b1; #1;
        chk("t2_early", 32'(c1), 32'd0);
        @(negedge clock); #1;
        chk("t2_complete", 32'(c1), 32'd1);
        @(negedge clock); en1 = 1'b0; #1;
        chk("t2_rs1", v1a, 32'd7);
        chk("t2_rs2", v1b, 32'd9);
        chk("t2_imm", imm1, 32'd0);
        chk("t2_funct7", 32'(f7_1), 32'd0);
        chk("t2_rd", 32'(rd1), 32'd3);
        chk("t2_opcode", 32'(op1), 32'h33);

        // beq x0,x0,-4
        @(negedge clock); instr = 32'hFE000EE3; en1 = 1'b1;
        @(negedge clock); #1;
        chk("t3b_complete", 32'(c1), 32'd1);
        @(negedge clock); en1 = 1'b0; #1;
        chk("t3b_imm", imm1, 32'hFFFFFFFC);
        chk("t3b_rs1", v1a, 32'd0);
        chk("t3b_rs2", v1b, 32'd0);

        // sw x5,-8(x2)
        @(negedge clock); instr = 32'hFE512C23; en1 = 1'b1;
        @(negedge clock);
        @(negedge clock); en1 = 1'b0; #1;
        chk("t3s_imm", imm1, 32'hFFFFFFF8);
        chk("t3s_rs1", v1a, 32'd7);
        chk("t3s_rs2", v1b, 32'd9);
        chk("t3s_funct3", 32'(f3_1), 32'd2);

        // lui x1,0x12345 (rs1 field nonzero but unused)
        @(negedge clock); instr = 32'h123450B7; en1 = 1'b1;
        @(negedge clock);
        @(negedge clock); en1 = 1'b0; #1;
        chk("t3u_imm", imm1, 32'h12345000);
        chk("t3u_rs1", v1a, 32'd0);
        chk("t3u_opcode", 32'(op1), 32'h37);

        // illegal opcode halts until reset
        @(negedge clock); instr = 32'hFFFFFFFF; en1 = 1'b1; #1;
        chk("t4_wait", 32'(c1), 32'd0);
        @(negedge clock); #1;
        chk("t4_no_complete", 32'(c1), 32'd0);
        chk("t4_not_yet_halted", 32'(h1), 32'd0);
        @(negedge clock); #1;
        chk("t4_halted", 32'(h1), 32'd1);
        chk("t4_no_complete2", 32'(c1), 32'd0);
        @(negedge clock); instr = 32'h00500093; #1;
        chk("t4_sticky", 32'(h1), 32'd1);
        chk("t4_legal_ignored", 32'(c1), 32'd0);
        @(negedge clock); #1;
        chk("t4_hold_opcode", 32'(op1), 32'h37);
        chk("t4_hold_imm", imm1, 32'h12345000);
        @(negedge clock); reset = 1'b1; en1 = 1'b0;
        @(negedge clock); reset = 1'b0; #1;
        chk("t4_unhalt", 32'(h1), 32'd0);
        chk("t4_rst_opcode", 32'(op1), 32'd0);
        chk("t4_rst_imm", imm1, 32'd0);

        // latency 2: aborted count, then full count
        @(negedge clock); en2 = 1'b1; #1;
        chk("t5_a1", 32'(c2), 32'd0);
        @(negedge clock); en2 = 1'b0; #1;
        chk("t5_abort", 32'(c2), 32'd0);
        @(negedge clock); en2 = 1'b1; #1;
        chk("t5_b1", 32'(c2), 32'd0);
        @(negedge clock); #1;
        chk("t5_b2", 32'(c2), 32'd0);
        chk("t5_hold_imm", imm2, 32'd0);
        chk("t5_hold_opcode", 32'(op2), 32'd0);
        @(negedge clock); #1;
        chk("t5_complete", 32'(c2), 32'd1);
        @(negedge clock); en2 = 1'b0; #1;
        chk("t5_imm", imm2, 32'd5);
        chk("t5_opcode", 32'(op2), 32'h13);

        // reset mid-count
        @(negedge clock); en2 = 1'b1; #1;
        chk("t6_c1", 32'(c2), 32'd0);
        @(negedge clock); reset = 1'b1; #1;
        chk("t6_c2", 32'(c2), 32'd0);
        @(negedge clock); reset = 1'b0; #1;
        chk("t6_after", 32'(c2), 32'd0);
        chk("t6_imm", imm2, 32'd0);
        chk("t6_opcode", 32'(op2), 32'd0);
        chk("t6_rd", 32'(rd2), 32'd0);
        @(negedge clock); #1;
        chk("t6_recount", 32'(c2), 32'd0);
        en2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
